// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and round-constant table for the AES-128 key schedule.
package aes_pkg;

   localparam int unsigned NR     = 10;
   localparam int unsigned NK     = 4;
   localparam int unsigned NW     = 44;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned RK_W   = 128;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CNT_W  = 6;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_e;

   localparam logic [7:0] RCON [NR] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Rcon indexed by round 1..10; other rounds return 0
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] v;
      v = 8'h00;
      if ((rnd != 4'd0) && (rnd <= 4'(NR))) begin
         v = RCON[4'(rnd - 4'd1)];
      end
      return v;
   endfunction

endpackage

// File: rtl/ssbox.sv
// 32-bit column S-box: four parallel AES SubBytes lookups, purely combinational.
module ssbox
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_word_c
);

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the MSBs of the table
   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      logic [10:0] idx;
      idx = 11'd2047 - {b, 3'b000};
      return SBOX_TBL[idx -: 8];
   endfunction

   assign o_word_c = {sub_byte(i_word[31:24]), sub_byte(i_word[23:16]),
                      sub_byte(i_word[15:8]),  sub_byte(i_word[7:0])};

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: one word per clock into a 44-word store,
// with a registered random-access round-key read port.
module aes128_key_expand
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [RK_W-1:0]  key_in,
   output logic             busy,
   output logic             done,
   output logic             keys_valid,
   input  logic [IDX_W-1:0] rk_idx,
   output logic [RK_W-1:0]  rk_out
);

   state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic                r_kv, w_kv_nxt;
   logic                w_load, w_wr;
   logic [WORD_W-1:0]   r_words [NW];
   logic [RK_W-1:0]     r_rk, w_rk_nxt;

   logic [WORD_W-1:0]   w_prev, w_back4, w_rot, w_sub, w_temp, w_new;
   logic [CNT_W-1:0]    w_base;

   // Word recurrence: w[i] = w[i-4] ^ temp
   assign w_prev  = r_words[CNT_W'(r_cnt - CNT_W'(1))];
   assign w_back4 = r_words[CNT_W'(r_cnt - CNT_W'(NK))];
   assign w_rot   = {w_prev[23:0], w_prev[31:24]};

   ssbox u_ssbox (
      .i_word   (w_rot),
      .o_word_c (w_sub)
   );

   assign w_temp = (r_cnt[1:0] == 2'b00) ? (w_sub ^ {rcon(r_cnt[5:2]), 24'h000000})
                                         : w_prev;
   assign w_new  = w_back4 ^ w_temp;

   // Read port mux; indices past the last round read as zero
   assign w_base = {rk_idx, 2'b00};
   always_comb begin
      w_rk_nxt = '0;
      if (rk_idx <= IDX_W'(NR)) begin
         w_rk_nxt = {r_words[w_base], r_words[w_base | CNT_W'(1)],
                     r_words[w_base | CNT_W'(2)], r_words[w_base | CNT_W'(3)]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_kv_nxt    = r_kv;
      w_load      = 1'b0;
      w_wr        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_cnt_nxt   = CNT_W'(NK);
               w_kv_nxt    = 1'b0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            w_wr      = 1'b1;
            w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
            if (r_cnt == CNT_W'(NW - 1)) begin
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_kv_nxt    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_kv    <= 1'b0;
         r_rk    <= '0;
         for (int k = 0; k < NW; k++) begin
            r_words[k] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_kv    <= w_kv_nxt;
         r_rk    <= w_rk_nxt;
         if (w_load) begin
            r_words[0] <= key_in[127:96];
            r_words[1] <= key_in[95:64];
            r_words[2] <= key_in[63:32];
            r_words[3] <= key_in[31:0];
         end else if (w_wr) begin
            r_words[r_cnt] <= w_new;
         end
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign keys_valid = r_kv;
   assign rk_out     = r_rk;

endmodule
